// File: rtl/icache_if.sv
// CPU fetch channel, memory burst-read channel and perf counters of icache_dm.
// slave: the cache side; master: the CPU/memory environment side.
interface icache_if;
  logic        from_cpu_inst_req_valid;
  logic [31:0] from_cpu_inst_req_addr;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready;
  logic        from_mem_rd_rsp_valid;
  logic [31:0] from_mem_rd_rsp_data;
  logic        from_mem_rd_rsp_last;
  logic        to_mem_rd_rsp_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  from_cpu_inst_req_valid,
    input  from_cpu_inst_req_addr,
    output to_cpu_inst_req_ready,
    output to_cpu_cache_rsp_valid,
    output to_cpu_cache_rsp_data,
    input  from_cpu_cache_rsp_ready,
    output to_mem_rd_req_valid,
    output to_mem_rd_req_addr,
    input  from_mem_rd_req_ready,
    input  from_mem_rd_rsp_valid,
    input  from_mem_rd_rsp_data,
    input  from_mem_rd_rsp_last,
    output to_mem_rd_rsp_ready,
    output hit_cnt,
    output miss_cnt
  );

  modport master (
    output from_cpu_inst_req_valid,
    output from_cpu_inst_req_addr,
    input  to_cpu_inst_req_ready,
    input  to_cpu_cache_rsp_valid,
    input  to_cpu_cache_rsp_data,
    output from_cpu_cache_rsp_ready,
    input  to_mem_rd_req_valid,
    input  to_mem_rd_req_addr,
    output from_mem_rd_req_ready,
    output from_mem_rd_rsp_valid,
    output from_mem_rd_rsp_data,
    output from_mem_rd_rsp_last,
    input  to_mem_rd_rsp_ready,
    input  hit_cnt,
    input  miss_cnt
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only I-cache, one fetch in flight, burst line refill.
// Ports: clk, rst (sync, active-high), bus (icache_if.slave).
module icache_dm #(
  parameter int SETS  = 8,
  parameter int WORDS = 8
) (
  input  logic    clk,
  input  logic    rst,
  icache_if.slave bus
);
  localparam int IDX   = $clog2(SETS);
  localparam int WB    = $clog2(WORDS);
  localparam int OFF   = WB + 2;
  localparam int TAG_W = 32 - IDX - OFF;
  localparam int CW    = WB + 1;
  localparam logic [CW-1:0] CMAX = CW'(WORDS);

  typedef enum logic [5:0] {
    WAIT   = 6'b000001,
    TAG_RD = 6'b000010,
    MEM_RD = 6'b000100,
    RECV   = 6'b001000,
    REFILL = 6'b010000,
    RESP   = 6'b100000
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [31:0]      buf_q [WORDS];
  logic [31:0]      buf_d [WORDS];
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      data_q [SETS][WORDS];
  logic             line_we;

  logic [TAG_W-1:0] tag;
  logic [IDX-1:0]   idx;
  logic [WB-1:0]    word;
  logic             hit;
  logic             unused_addr;

  assign tag         = addr_q[31 -: TAG_W];
  assign idx         = addr_q[OFF +: IDX];
  assign word        = addr_q[2 +: WB];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr = ^addr_q[1:0];

  assign bus.to_cpu_inst_req_ready  = (state_q == WAIT);
  assign bus.to_cpu_cache_rsp_valid = (state_q == RESP);
  assign bus.to_cpu_cache_rsp_data  = rdata_q;
  assign bus.to_mem_rd_req_valid    = (state_q == MEM_RD);
  assign bus.to_mem_rd_req_addr     = {addr_q[31:OFF], {OFF{1'b0}}};
  assign bus.to_mem_rd_rsp_ready    = (state_q == RECV);
  assign bus.hit_cnt                = hit_cnt_q;
  assign bus.miss_cnt               = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    buf_d      = buf_q;
    line_we    = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (bus.from_cpu_inst_req_valid) begin
          addr_d  = bus.from_cpu_inst_req_addr;
          state_d = TAG_RD;
        end
      end
      TAG_RD: begin
        if (hit) begin
          rdata_d   = data_q[idx][word];
          hit_cnt_d = hit_cnt_q + 32'd1;
          state_d   = RESP;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = MEM_RD;
        end
      end
      MEM_RD: begin
        if (bus.from_mem_rd_req_ready) state_d = RECV;
      end
      RECV: begin
        if (bus.from_mem_rd_rsp_valid) begin
          // counter saturates at WORDS; surplus beats dropped
          if (cnt_q < CMAX) begin
            buf_d[cnt_q[WB-1:0]] = bus.from_mem_rd_rsp_data;
            cnt_d = cnt_q + 1'b1;
          end
          if (bus.from_mem_rd_rsp_last) state_d = REFILL;
        end
      end
      REFILL: begin
        line_we      = 1'b1;
        valid_d[idx] = 1'b1;
        rdata_d      = buf_q[word];
        state_d      = RESP;
      end
      RESP: begin
        if (bus.from_cpu_cache_rsp_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT;
      addr_q     <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // line storage carries no reset; valid_q gates it
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (line_we && !rst) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= buf_q;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm.
// Drives the CPU and memory sides of icache_if.
module tb_icache_dm;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  icache_if bus();

  icache_dm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] a, output bit ok);
    int n = 0;
    bus.from_cpu_inst_req_valid = 1'b1;
    bus.from_cpu_inst_req_addr  = a;
    while (!bus.to_cpu_inst_req_ready && n < 50) begin
      tick();
      n++;
    end
    ok = bus.to_cpu_inst_req_ready;
    tick();
    bus.from_cpu_inst_req_valid = 1'b0;
  endtask

  task automatic serve_burst(
    input  logic [31:0] base,
    input  int          nbeats,
    input  int          rdy_delay,
    input  bit          gaps,
    input  bit          with_last,
    output logic [31:0] got_addr,
    output bit          stable,
    output bit          seen
  );
    int n = 0;
    stable   = 1'b1;
    seen     = 1'b0;
    got_addr = '0;
    while (!bus.to_mem_rd_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.to_mem_rd_req_valid) return;
    seen     = 1'b1;
    got_addr = bus.to_mem_rd_req_addr;
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      if (!bus.to_mem_rd_req_valid ||
          bus.to_mem_rd_req_addr !== got_addr)
        stable = 1'b0;
    end
    bus.from_mem_rd_req_ready = 1'b1;
    tick();
    bus.from_mem_rd_req_ready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      if (!bus.to_mem_rd_rsp_ready) stable = 1'b0;
      bus.from_mem_rd_rsp_valid = 1'b1;
      bus.from_mem_rd_rsp_data  = base + 32'(b);
      bus.from_mem_rd_rsp_last  = with_last && (b == nbeats - 1);
      tick();
      bus.from_mem_rd_rsp_valid = 1'b0;
      bus.from_mem_rd_rsp_last  = 1'b0;
    end
  endtask

  task automatic get_rsp(output logic [31:0] d, output bit ok);
    int n = 0;
    while (!bus.to_cpu_cache_rsp_valid && n < 50) begin
      tick();
      n++;
    end
    ok = bus.to_cpu_cache_rsp_valid;
    d  = bus.to_cpu_cache_rsp_data;
    bus.from_cpu_cache_rsp_ready = 1'b1;
    tick();
    bus.from_cpu_cache_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (bus.to_cpu_inst_req_ready !== 1'b1 ||
        bus.to_cpu_cache_rsp_valid !== 1'b0 ||
        bus.to_mem_rd_req_valid !== 1'b0 ||
        bus.to_mem_rd_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got rdy=%b rv=%b mv=%b mr=%b exp 1000",
        bus.to_cpu_inst_req_ready, bus.to_cpu_cache_rsp_valid,
        bus.to_mem_rd_req_valid, bus.to_mem_rd_rsp_ready);
    end
    checks++;
    if (bus.to_cpu_cache_rsp_data !== 32'h0 ||
        bus.to_mem_rd_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h exp 0 0",
        bus.to_cpu_cache_rsp_data, bus.to_mem_rd_req_addr);
    end
    checks++;
    if (bus.hit_cnt !== 32'd0 || bus.miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got hit=%0d miss=%0d exp 0 0",
        bus.hit_cnt, bus.miss_cnt);
    end
  endtask

  // fetch that must miss; checks refill address, latency and data
  task automatic miss_fetch(
    input string       name,
    input logic [31:0] a,
    input logic [31:0] exp_line,
    input logic [31:0] base,
    input logic [31:0] exp_data,
    input int          nbeats,
    input int          rdy_delay,
    input bit          gaps
  );
    bit ok, stable, seen;
    logic [31:0] ga, d;
    send_req(a, ok);
    serve_burst(base, nbeats, rdy_delay, gaps, 1'b1, ga, stable, seen);
    checks++;
    if (!ok || !seen || ga !== exp_line || !stable) begin
      errors++;
      $display("FAIL %s_req: got ok=%b seen=%b addr=%h stable=%b exp addr %h",
        name, ok, seen, ga, stable, exp_line);
    end
    checks++;
    if (bus.to_cpu_cache_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat1: got rsp_valid=1 exp 0", name);
    end
    tick();
    checks++;
    if (bus.to_cpu_cache_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_lat2: got rsp_valid=0 exp 1", name);
    end
    get_rsp(d, ok);
    checks++;
    if (!ok || d !== exp_data) begin
      errors++;
      $display("FAIL %s_data: got %h exp %h", name, d, exp_data);
    end
  endtask

  // fetch that must hit; checks 2-cycle latency and no memory request
  task automatic hit_fetch(
    input string       name,
    input logic [31:0] a,
    input logic [31:0] exp_data
  );
    bit ok;
    logic [31:0] d;
    send_req(a, ok);
    checks++;
    if (!ok || bus.to_cpu_cache_rsp_valid !== 1'b0 ||
        bus.to_mem_rd_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_tagrd: got ok=%b rv=%b mv=%b exp 1 0 0", name,
        ok, bus.to_cpu_cache_rsp_valid, bus.to_mem_rd_req_valid);
    end
    tick();
    checks++;
    if (bus.to_cpu_cache_rsp_valid !== 1'b1 ||
        bus.to_mem_rd_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat: got rv=%b mv=%b exp 1 0", name,
        bus.to_cpu_cache_rsp_valid, bus.to_mem_rd_req_valid);
    end
    get_rsp(d, ok);
    checks++;
    if (!ok || d !== exp_data) begin
      errors++;
      $display("FAIL %s_data: got %h exp %h", name, d, exp_data);
    end
  endtask

  task automatic test_cold_miss();
    miss_fetch("cold", 32'h40, 32'h40, 32'h1000, 32'h1000, 8, 0, 1'b0);
    checks++;
    if (bus.miss_cnt !== 32'd1 || bus.hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL cold_cnt: got hit=%0d miss=%0d exp 0 1",
        bus.hit_cnt, bus.miss_cnt);
    end
  endtask

  task automatic test_hit();
    hit_fetch("hit", 32'h4C, 32'h1003);
    checks++;
    if (bus.hit_cnt !== 32'd1) begin
      errors++;
      $display("FAIL hit_cnt: got %0d exp 1", bus.hit_cnt);
    end
  endtask

  task automatic test_conflict();
    miss_fetch("evict", 32'h140, 32'h140, 32'h2000, 32'h2000,
      8, 0, 1'b0);
    miss_fetch("refetch", 32'h44, 32'h40, 32'h3000, 32'h3001,
      8, 0, 1'b0);
    checks++;
    if (bus.miss_cnt !== 32'd3 || bus.hit_cnt !== 32'd1) begin
      errors++;
      $display("FAIL conflict_cnt: got hit=%0d miss=%0d exp 1 3",
        bus.hit_cnt, bus.miss_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] d;
    miss_fetch("bp_mem", 32'h68, 32'h60, 32'h4000, 32'h4002,
      8, 5, 1'b1);
    hit_fetch("bp_beat7", 32'h78, 32'h4006);
    send_req(32'h7C, ok);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.to_cpu_cache_rsp_valid !== 1'b1 ||
          bus.to_cpu_cache_rsp_data !== 32'h4007 ||
          bus.to_cpu_inst_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_rsp%0d: got rv=%b d=%h rdy=%b exp 1 4007 0", i,
          bus.to_cpu_cache_rsp_valid, bus.to_cpu_cache_rsp_data,
          bus.to_cpu_inst_req_ready);
      end
      tick();
    end
    get_rsp(d, ok);
    checks++;
    if (!ok || d !== 32'h4007 || bus.to_cpu_inst_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %h rdy=%b exp 4007 1",
        d, bus.to_cpu_inst_req_ready);
    end
    checks++;
    if (bus.hit_cnt !== 32'd3 || bus.miss_cnt !== 32'd4) begin
      errors++;
      $display("FAIL bp_cnt: got hit=%0d miss=%0d exp 3 4",
        bus.hit_cnt, bus.miss_cnt);
    end
  endtask

  task automatic test_reset_mid_refill();
    bit ok, stable, seen;
    logic [31:0] ga;
    send_req(32'h80, ok);
    serve_burst(32'h7000, 4, 0, 1'b0, 1'b0, ga, stable, seen);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.to_cpu_inst_req_ready !== 1'b1 ||
        bus.to_mem_rd_rsp_ready !== 1'b0 ||
        bus.miss_cnt !== 32'd0 || bus.hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_rst: got rdy=%b mr=%b hit=%0d miss=%0d exp 1 0 0 0",
        bus.to_cpu_inst_req_ready, bus.to_mem_rd_rsp_ready,
        bus.hit_cnt, bus.miss_cnt);
    end
    miss_fetch("mid_refetch", 32'h80, 32'h80, 32'h5000, 32'h5000,
      8, 0, 1'b0);
    miss_fetch("mid_old", 32'h40, 32'h40, 32'h5100, 32'h5100,
      8, 0, 1'b0);
    checks++;
    if (bus.miss_cnt !== 32'd2) begin
      errors++;
      $display("FAIL mid_cnt: got miss=%0d exp 2", bus.miss_cnt);
    end
  endtask

  task automatic test_index_wrap();
    miss_fetch("wrap", 32'hE0, 32'hE0, 32'h6000, 32'h6000, 8, 0, 1'b0);
    hit_fetch("wrap_last", 32'hFC, 32'h6007);
  endtask

  task automatic test_extra_beats();
    miss_fetch("extra", 32'hA0, 32'hA0, 32'h8000, 32'h8000,
      10, 0, 1'b0);
    hit_fetch("extra_w7", 32'hBC, 32'h8007);
    checks++;
    if (bus.hit_cnt !== 32'd2 || bus.miss_cnt !== 32'd4) begin
      errors++;
      $display("FAIL final_cnt: got hit=%0d miss=%0d exp 2 4",
        bus.hit_cnt, bus.miss_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.from_cpu_inst_req_valid  = 1'b0;
    bus.from_cpu_inst_req_addr   = '0;
    bus.from_cpu_cache_rsp_ready = 1'b0;
    bus.from_mem_rd_req_ready    = 1'b0;
    bus.from_mem_rd_rsp_valid    = 1'b0;
    bus.from_mem_rd_rsp_data     = '0;
    bus.from_mem_rd_rsp_last     = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_reset_mid_refill();
    test_index_wrap();
    test_extra_beats();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
